// File: rtl/gayle_nport_if.sv
// CPU-side bus of the Gayle IDE front-end: address/data, read/write
// qualifiers and the $DAxxxx/$DExxxx region decodes.
`timescale 1ns/1ps
interface gayle_nport_if;
  logic [23:1] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd;
  logic        wr;
  logic        longword;
  logic        sel_ide;
  logic        sel_gayle;

  modport master (
    output addr, data_in, rd, wr, longword, sel_ide, sel_gayle,
    input  data_out
  );

  modport slave (
    input  addr, data_in, rd, wr, longword, sel_ide, sel_gayle,
    output data_out
  );
endinterface

// File: rtl/gayle_nport.sv
// Gayle IDE front-end for up to four IDE cores: CS/CFG/INTENA/INTREQ-change
// registers, the serial Gayle ID register and task-file routing to the
// selected port.
`timescale 1ns/1ps
module gayle_nport #(
  parameter int         NUM_PORTS = 2,
  parameter logic [7:0] GAYLE_ID  = 8'hD0,
  parameter logic [7:0] CS_RESET  = 8'h00
) (
  input  logic                      clk,
  input  logic                      reset,
  gayle_nport_if.slave              bus,
  output logic                      irq,
  output logic                      nrdy,
  output logic                      led,
  output logic                      port_rst,
  output logic [2:0]                port_addr,
  output logic [NUM_PORTS-1:0]      port_rd,
  output logic [NUM_PORTS-1:0]      port_wr,
  output logic [15:0]               port_wdata,
  output logic                      port_io32,
  input  logic [32*NUM_PORTS-1:0]   port_rdata,
  input  logic [NUM_PORTS-1:0]      port_irq,
  input  logic [NUM_PORTS-1:0]      port_nodata,
  input  logic [NUM_PORTS-1:0]      port_drq
);

  // Region decodes
  logic tfr, sel_cs, sel_intchg, sel_intena, sel_cfg, gayleid;
  assign tfr        = bus.sel_ide & (bus.addr[15:14] == 2'b00);
  assign sel_cs     = bus.sel_ide & (bus.addr[15:12] == 4'h8);
  assign sel_intchg = bus.sel_ide & (bus.addr[15:12] == 4'h9);
  assign sel_intena = bus.sel_ide & (bus.addr[15:12] == 4'hA);
  assign sel_cfg    = bus.sel_ide & (bus.addr[15:12] == 4'hB);
  assign gayleid    = bus.sel_gayle & (bus.addr[15:12] == 4'h1);

  // Edge-detect history and state
  logic                 wr_q, rst_q, lw_q, rdid_q;
  logic [NUM_PORTS-1:0] pirq_q;
  logic [5:0]           cs_mask;
  logic [1:0]           cs;
  logic [3:0]           cfg;
  logic [NUM_PORTS-1:0] intena, intchg, intchg_nxt, data_bits;
  logic [2:0]           id_cnt;
  logic [15:0]          intena_rd, intchg_rd, rdata;
  logic [31:0]          sel_word;
  logic                 sel_nodata;
  logic [1:0]           p;
  logic                 wr_stb, id_fall;

  // Address bits that carry no meaning inside this block
  logic unused_addr;
  assign unused_addr = &{1'b0, bus.addr[23:16], bus.addr[11:5]};

  // A held wr produces a single strobe, and none while reset is asserted
  assign wr_stb  = bus.wr & ~wr_q & ~reset;
  assign id_fall = rdid_q & ~(bus.rd & gayleid);

  // Port index: the top address bit only joins in for three- or four-port builds
  always_comb begin
    p = {1'b0, bus.addr[12]};
    if (NUM_PORTS > 2) p = bus.addr[13:12];
  end

  // Per-port selection, bit-reversed register views and the INTREQ update
  always_comb begin
    sel_word   = 32'h0;
    sel_nodata = 1'b0;
    port_rd    = '0;
    port_wr    = '0;
    data_bits  = '0;
    intena_rd  = 16'h0;
    intchg_rd  = 16'h0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (p == 2'(i)) begin
        sel_word   = port_rdata[32*i +: 32];
        sel_nodata = port_nodata[i];
        port_rd[i] = ~reset & bus.rd & tfr;
        port_wr[i] = wr_stb & tfr;
      end
      data_bits[i]      = bus.data_in[15-i];
      intena_rd[15-i]   = intena[i];
      intchg_rd[15-i]   = intchg[i];
    end
    intchg_nxt = intchg;
    if (wr_stb & sel_intchg) intchg_nxt = intchg & data_bits;
    // A new interrupt edge beats a clearing write in the same cycle
    intchg_nxt = intchg_nxt | (port_irq & ~pirq_q);
  end

  // CPU read data mux; out-of-range ports fall through to zero
  always_comb begin
    rdata = 16'h0;
    if (tfr & (|port_rd | bus.rd & (32'(p) < NUM_PORTS)))
      rdata = (lw_q & bus.addr[1]) ? sel_word[31:16] : sel_word[15:0];
    else if (sel_cs)
      rdata = {cs_mask[5] | (|port_irq), cs_mask[4:0], cs, 8'h00};
    else if (sel_intchg)
      rdata = intchg_rd;
    else if (sel_intena)
      rdata = intena_rd;
    else if (sel_cfg)
      rdata = {cfg, 12'h000};
    else if (gayleid)
      rdata = {GAYLE_ID[3'd7 - id_cnt], 15'h0000};
    bus.data_out = (bus.rd & ~reset) ? rdata : 16'h0000;
  end

  assign port_addr  = bus.addr[4:2];
  assign port_wdata = {bus.data_in[7:0], bus.data_in[15:8]};
  assign port_io32  = ~reset & bus.rd & (bus.longword | lw_q);
  assign nrdy       = tfr & (bus.addr[4:2] == 3'd0) & sel_nodata;
  assign led        = |port_drq;
  assign port_rst   = reset & ~rst_q;

  // History registers keep tracking through reset so a held wr or irq never re-fires
  always_ff @(posedge clk) begin
    wr_q   <= bus.wr;
    rst_q  <= reset;
    pirq_q <= port_irq;
  end

  // Register file, interrupt request, longword and Gayle ID sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_mask <= CS_RESET[7:2];
      cs      <= CS_RESET[1:0];
      cfg     <= 4'h0;
      intena  <= '0;
      intchg  <= '0;
      id_cnt  <= 3'd0;
      irq     <= 1'b0;
      lw_q    <= 1'b0;
      rdid_q  <= 1'b0;
    end else begin
      lw_q   <= bus.rd & bus.longword & (bus.addr[4:1] == 4'h0);
      rdid_q <= bus.rd & gayleid;
      irq    <= |(intchg & intena);
      intchg <= intchg_nxt;
      if (wr_stb & sel_cs) begin
        cs_mask <= bus.data_in[15:10];
        cs      <= bus.data_in[9:8];
      end
      if (wr_stb & sel_cfg)    cfg    <= bus.data_in[15:12];
      if (wr_stb & sel_intena) intena <= data_bits;
      if (wr_stb & gayleid)    id_cnt <= 3'd0;
      else if (id_fall)        id_cnt <= id_cnt + 3'd1;
    end
  end

endmodule
